// File: rtl/dma_io_port_fifo.sv
// dma_io_port_fifo: peripheral-side port of one DMA channel with RX/TX FIFOs, DREQ and wait-state handling
// Ports: clk, reset (async active-low), dir (0 RX / 1 TX), dev_wr_en/dev_wr_data/dev_full (RX push side),
//        dev_rd_en/dev_rd_data/dev_empty (TX show-ahead pop side), DACK/IOR/IOW/data (DMA bus),
//        DREQ (bit CH only), READY_IO (0 = wait state), err {tx_overflow, rx_underflow}, xfer_cnt.
// Optional: define DMA_IO_XFER_CNT_EN to count completed bus transfers on xfer_cnt; otherwise it reads 0.
module dma_io_port_fifo #(
    parameter int DW      = 8,
    parameter int DEPTH   = 8,
    parameter int CH      = 0,
    parameter int THRESH  = 4,
    parameter int WAIT_ST = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dir,
    input  logic          dev_wr_en,
    input  logic [DW-1:0] dev_wr_data,
    output logic          dev_full,
    input  logic          dev_rd_en,
    output logic [DW-1:0] dev_rd_data,
    output logic          dev_empty,
    input  logic [3:0]    DACK,
    input  logic          IOR,
    input  logic          IOW,
    inout  wire  [DW-1:0] data,
    output logic [3:0]    DREQ,
    output logic          READY_IO,
    output logic [1:0]    err,
    output logic [15:0]   xfer_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_HOLD} state_t;
    state_t state, state_nxt;
    logic [2:0] wcnt, wcnt_nxt;
    logic sel, sel_q, sel_rise, dir_q, dreq_q, rd_uf;
    logic rx_push, rx_pop, tx_push, tx_pop, tx_full, xfer_rd, xfer_wr;
    logic [DW-1:0] bus_q;
    logic [DW-1:0] rx_mem [DEPTH];
    logic [DW-1:0] tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] rx_count, tx_count, tx_free;
    assign sel         = DACK[CH] & (IOR | IOW);
    assign sel_rise    = sel & ~sel_q;
    // IOR wins when both strobes are high
    assign xfer_rd     = (state == S_XFER) & DACK[CH] & IOR;
    assign xfer_wr     = (state == S_XFER) & DACK[CH] & IOW & ~IOR;
    assign dev_full    = rx_count == CW'(DEPTH);
    assign dev_empty   = tx_count == '0;
    assign tx_full     = tx_count == CW'(DEPTH);
    assign tx_free     = CW'(DEPTH) - tx_count;
    assign rx_push     = dev_wr_en & ~dev_full;
    assign rx_pop      = xfer_rd & ~rd_uf;
    assign tx_push     = xfer_wr & ~tx_full;
    assign tx_pop      = dev_rd_en & ~dev_empty;
    assign dev_rd_data = tx_mem[tx_rp];
    assign READY_IO    = state != S_WAIT;
    assign DREQ        = 4'(dreq_q) << CH;
    // bus_q is captured at strobe start so the driven byte stays put through HOLD after the pop
    assign data        = (state != S_IDLE && DACK[CH] && IOR) ? bus_q : 'z;
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                wcnt_nxt = '0;
                if (sel_rise) state_nxt = (WAIT_ST > 0) ? S_WAIT : S_XFER;
            end
            S_WAIT: begin
                wcnt_nxt  = wcnt + 3'd1;
                state_nxt = !sel ? S_IDLE : (wcnt == 3'(WAIT_ST - 1)) ? S_XFER : S_WAIT;
            end
            S_XFER:  state_nxt = S_HOLD;
            default: state_nxt = sel ? S_HOLD : S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            sel_q    <= 1'b0;
            dir_q    <= 1'b0;
            dreq_q   <= 1'b0;
            rd_uf    <= 1'b0;
            bus_q    <= '0;
            err      <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            tx_wp    <= '0;
            tx_rp    <= '0;
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            sel_q <= sel;
            if (state == S_IDLE) dir_q <= dir;
            // underflow is decided at strobe start; only IOR can drain RX, so it cannot change before XFER
            if (state == S_IDLE && sel_rise) begin
                rd_uf <= rx_count == '0;
                bus_q <= (rx_count == '0) ? '1 : rx_mem[rx_rp];
            end
            // set at threshold, held until the level reaches zero (burst drain/fill)
            dreq_q <= dir_q ? ((tx_free >= CW'(THRESH)) | (dreq_q & (tx_free != '0)))
                            : ((rx_count >= CW'(THRESH)) | (dreq_q & (rx_count != '0)));
            err      <= err | {xfer_wr & tx_full, xfer_rd & rd_uf};
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= dev_wr_data;
        if (tx_push) tx_mem[tx_wp] <= data;
    end
`ifdef DMA_IO_XFER_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) xfer_cnt <= '0;
        else if (rx_pop | tx_push) xfer_cnt <= xfer_cnt + 16'd1;
    end
`else
    assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_dma_io_port_fifo.sv
// tb_dma_io_port_fifo: randomized self-checking bench for dma_io_port_fifo against a queue-based model
module tb_dma_io_port_fifo;
    localparam int DW = 8, DEPTH = 8, CH = 2, THRESH = 4, WAIT_ST = 2;
`ifdef DMA_IO_XFER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clk = 0, reset = 0, dir = 0, dev_wr_en = 0, dev_rd_en = 0, IOR = 0, IOW = 0, tb_drv = 0;
    logic [DW-1:0] dev_wr_data = 0, tb_val = 0, dev_rd_data;
    logic dev_full, dev_empty, READY_IO;
    logic [3:0] DACK = 0, DREQ;
    logic [1:0] err;
    logic [15:0] xfer_cnt;
    wire [DW-1:0] data;
    int tests = 0, fails = 0;
    logic [DW-1:0] rxq[$], txq[$];
    logic m_dreq;
    logic [1:0] m_err;
    logic [15:0] m_cnt;
    assign data = tb_drv ? tb_val : 'z;
    always #5 clk = ~clk;
    dma_io_port_fifo #(.DW(DW), .DEPTH(DEPTH), .CH(CH), .THRESH(THRESH), .WAIT_ST(WAIT_ST)) dut (
        .clk(clk), .reset(reset), .dir(dir), .dev_wr_en(dev_wr_en), .dev_wr_data(dev_wr_data),
        .dev_full(dev_full), .dev_rd_en(dev_rd_en), .dev_rd_data(dev_rd_data), .dev_empty(dev_empty),
        .DACK(DACK), .IOR(IOR), .IOW(IOW), .data(data), .DREQ(DREQ), .READY_IO(READY_IO),
        .err(err), .xfer_cnt(xfer_cnt)
    );
    function automatic logic [3:0] exp_dreq();
        return m_dreq ? 4'(1 << CH) : 4'h0;
    endfunction
    function automatic logic [15:0] exp_cnt();
        return CNT_EN ? m_cnt : 16'h0;
    endfunction
    function automatic void upd_dreq(int lvl);
        m_dreq = (lvl >= THRESH) ? 1'b1 : (lvl == 0) ? 1'b0 : m_dreq;
    endfunction
    task automatic do_reset(input bit d);
        @(negedge clk);
        reset = 0; dir = d; dev_wr_en = 0; dev_rd_en = 0; IOR = 0; IOW = 0; DACK = 0; tb_drv = 0;
        @(negedge clk);
        reset = 1;
        rxq.delete(); txq.delete(); m_dreq = 0; m_err = 0; m_cnt = 0;
        upd_dreq(d ? DEPTH : 0);
        repeat (2) @(negedge clk);
    endtask
    task automatic push(input logic [DW-1:0] v);
        dev_wr_en = 1; dev_wr_data = v;
        @(negedge clk);
        dev_wr_en = 0;
        @(negedge clk);
        if (rxq.size() < DEPTH) rxq.push_back(v);
        upd_dreq(rxq.size());
    endtask
    task automatic dev_pop();
        dev_rd_en = 1;
        @(negedge clk);
        dev_rd_en = 0;
        @(negedge clk);
        if (txq.size() > 0) void'(txq.pop_front());
        upd_dreq(DEPTH - txq.size());
    endtask
    // one DMA strobe of len cycles; returns the last bus value seen and the count of wait-state cycles
    task automatic strobe(input bit rd, input logic [DW-1:0] wv, input int len,
                          output logic [DW-1:0] rv, output int lows);
        @(negedge clk);
        DACK = 4'(1 << CH); IOR = rd; IOW = ~rd; tb_drv = ~rd; tb_val = wv;
        lows = 0;
        repeat (len) begin
            @(negedge clk);
            lows += int'(READY_IO == 1'b0);
            rv = data;
        end
        DACK = 0; IOR = 0; IOW = 0; tb_drv = 0;
        @(negedge clk);
    endtask
    function automatic logic [DW-1:0] model_read();
        logic [DW-1:0] v;
        if (rxq.size() == 0) begin
            m_err[0] = 1'b1;
            v = '1;
        end else begin
            v = rxq.pop_front();
            m_cnt++;
        end
        upd_dreq(rxq.size());
        return v;
    endfunction
    function automatic void model_write(input logic [DW-1:0] v);
        if (txq.size() < DEPTH) begin
            txq.push_back(v);
            m_cnt++;
        end else m_err[1] = 1'b1;
        upd_dreq(DEPTH - txq.size());
    endfunction
    task automatic test_reset();
        logic [DW-1:0] rv, ev;
        int lows;
        do_reset(0);
        tests++; if (READY_IO !== 1'b1 || DREQ !== 4'h0 || err !== 2'b00 || dev_full !== 1'b0 || dev_empty !== 1'b1 || xfer_cnt !== 16'h0) begin fails++; $display("FAIL reset_state got ready=%b dreq=%h err=%b full=%b empty=%b cnt=%h", READY_IO, DREQ, err, dev_full, dev_empty, xfer_cnt); end
        repeat (3) push(8'($urandom));
        @(negedge clk);
        DACK = 4'(1 << CH); IOR = 1;
        @(negedge clk);
        tests++; if (READY_IO !== 1'b0) begin fails++; $display("FAIL reset_pre_wait got ready=%b exp 0", READY_IO); end
        #1 reset = 0;
        #1;
        tests++; if (READY_IO !== 1'b1 || DREQ !== 4'h0 || err !== 2'b00 || dev_empty !== 1'b1 || dev_full !== 1'b0) begin fails++; $display("FAIL reset_async got ready=%b dreq=%h err=%b empty=%b full=%b", READY_IO, DREQ, err, dev_empty, dev_full); end
        DACK = 0; IOR = 0;
        @(negedge clk);
        reset = 1;
        rxq.delete(); m_dreq = 0; m_err = 0; m_cnt = 0;
        @(negedge clk);
        strobe(1, 0, 4, rv, lows);
        ev = model_read();
        tests++; if (rv !== ev || err !== m_err) begin fails++; $display("FAIL reset_rx_cleared got data=%h err=%b exp data=%h err=%b", rv, err, ev, m_err); end
    endtask
    task automatic test_rx_burst();
        logic [DW-1:0] rv, ev;
        int lows;
        do_reset(0);
        for (int i = 0; i < 3; i++) push(8'hA1 + 8'(i));
        tests++; if (DREQ !== 4'h0) begin fails++; $display("FAIL rx_dreq_below got %h exp 0", DREQ); end
        dev_wr_en = 1; dev_wr_data = 8'hA4;
        @(negedge clk);
        dev_wr_en = 0;
        tests++; if (DREQ !== 4'h0) begin fails++; $display("FAIL rx_dreq_latency got %h exp 0", DREQ); end
        @(negedge clk);
        rxq.push_back(8'hA4); upd_dreq(rxq.size());
        tests++; if (DREQ !== exp_dreq() || DREQ !== 4'(1 << CH)) begin fails++; $display("FAIL rx_dreq_set got %h exp %h", DREQ, 4'(1 << CH)); end
        for (int i = 0; i < 4; i++) begin
            strobe(1, 0, 4, rv, lows);
            ev = model_read();
            tests++; if (rv !== ev || DREQ !== exp_dreq()) begin fails++; $display("FAIL rx_read%0d got data=%h dreq=%h exp data=%h dreq=%h", i, rv, DREQ, ev, exp_dreq()); end
        end
        tests++; if (err !== 2'b00 || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL rx_burst_end got err=%b cnt=%h exp err=00 cnt=%h", err, xfer_cnt, exp_cnt()); end
    endtask
    task automatic test_wait_states();
        logic [DW-1:0] rv, ev;
        int lows;
        do_reset(0);
        repeat (2) push(8'($urandom));
        strobe(1, 0, 6, rv, lows);
        ev = model_read();
        tests++; if (lows !== WAIT_ST || rv !== ev) begin fails++; $display("FAIL wait_long got lows=%0d data=%h exp lows=%0d data=%h", lows, rv, WAIT_ST, ev); end
        for (int i = 0; i < 2; i++) begin
            strobe(1, 0, 4 + i, rv, lows);
            ev = model_read();
            tests++; if (rv !== ev || err !== m_err) begin fails++; $display("FAIL wait_single_pop%0d got data=%h err=%b exp data=%h err=%b", i, rv, err, ev, m_err); end
        end
    endtask
    task automatic test_tx_overflow();
        logic [DW-1:0] rv;
        int lows;
        do_reset(1);
        tests++; if (DREQ !== exp_dreq() || dev_empty !== 1'b1) begin fails++; $display("FAIL tx_dreq_idle got dreq=%h empty=%b exp dreq=%h empty=1", DREQ, dev_empty, exp_dreq()); end
        for (int i = 0; i < 9; i++) begin
            strobe(0, 8'h10 + 8'(i), 4, rv, lows);
            model_write(8'h10 + 8'(i));
            tests++; if (DREQ !== exp_dreq() || err !== m_err) begin fails++; $display("FAIL tx_write%0d got dreq=%h err=%b exp dreq=%h err=%b", i, DREQ, err, exp_dreq(), m_err); end
        end
        tests++; if (err !== 2'b10 || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL tx_overflow got err=%b cnt=%h exp err=10 cnt=%h", err, xfer_cnt, exp_cnt()); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (dev_empty !== 1'b0 || dev_rd_data !== txq[0]) begin fails++; $display("FAIL tx_pop%0d got data=%h empty=%b exp data=%h", i, dev_rd_data, dev_empty, txq[0]); end
            dev_pop();
        end
        tests++; if (dev_empty !== 1'b1 || DREQ !== exp_dreq()) begin fails++; $display("FAIL tx_drained got empty=%b dreq=%h exp empty=1 dreq=%h", dev_empty, DREQ, exp_dreq()); end
    endtask
    task automatic test_underflow();
        logic [DW-1:0] rv, ev, v;
        int lows;
        do_reset(0);
        strobe(1, 0, 4, rv, lows);
        ev = model_read();
        tests++; if (rv !== 8'hFF || rv !== ev || err !== 2'b01 || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL underflow got data=%h err=%b cnt=%h exp data=ff err=01 cnt=%h", rv, err, xfer_cnt, exp_cnt()); end
        v = 8'($urandom);
        push(v);
        strobe(1, 0, 5, rv, lows);
        ev = model_read();
        tests++; if (rv !== ev || err !== 2'b01 || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL underflow_sticky got data=%h err=%b cnt=%h exp data=%h err=01 cnt=%h", rv, err, xfer_cnt, ev, exp_cnt()); end
    endtask
    task automatic test_simul_push_pop();
        logic [DW-1:0] rv, ev, c;
        int lows;
        do_reset(0);
        repeat (2) push(8'($urandom));
        c = 8'($urandom);
        @(negedge clk);
        DACK = 4'(1 << CH); IOR = 1;
        repeat (3) @(negedge clk);
        dev_wr_en = 1; dev_wr_data = c;
        @(negedge clk);
        dev_wr_en = 0;
        rv = data;
        DACK = 0; IOR = 0;
        @(negedge clk);
        ev = model_read();
        rxq.push_back(c);
        upd_dreq(rxq.size());
        tests++; if (rv !== ev || DREQ !== exp_dreq()) begin fails++; $display("FAIL simul_pop got data=%h dreq=%h exp data=%h dreq=%h", rv, DREQ, ev, exp_dreq()); end
        for (int i = 0; i < 3; i++) begin
            strobe(1, 0, 4, rv, lows);
            ev = model_read();
            tests++; if (rv !== ev) begin fails++; $display("FAIL simul_order%0d got %h exp %h", i, rv, ev); end
        end
        tests++; if (err !== m_err || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL simul_end got err=%b cnt=%h exp err=%b cnt=%h", err, xfer_cnt, m_err, exp_cnt()); end
    endtask
    task automatic test_random();
        logic [DW-1:0] rv, ev, v;
        int lows;
        do_reset(0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) push(8'($urandom));
            else begin
                strobe(1, 0, int'($urandom_range(4, 6)), rv, lows);
                ev = model_read();
                tests++; if (rv !== ev) begin fails++; $display("FAIL rand_rx_data%0d got %h exp %h", i, rv, ev); end
            end
            tests++; if (DREQ !== exp_dreq() || dev_full !== (rxq.size() == DEPTH)) begin fails++; $display("FAIL rand_rx_state%0d got dreq=%h full=%b exp dreq=%h lvl=%0d", i, DREQ, dev_full, exp_dreq(), rxq.size()); end
        end
        tests++; if (err !== m_err || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL rand_rx_end got err=%b cnt=%h exp err=%b cnt=%h", err, xfer_cnt, m_err, exp_cnt()); end
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                v = 8'($urandom);
                strobe(0, v, int'($urandom_range(4, 6)), rv, lows);
                model_write(v);
            end else begin
                if (txq.size() > 0) begin
                    tests++; if (dev_rd_data !== txq[0]) begin fails++; $display("FAIL rand_tx_data%0d got %h exp %h", i, dev_rd_data, txq[0]); end
                end
                dev_pop();
            end
            tests++; if (DREQ !== exp_dreq() || dev_empty !== (txq.size() == 0)) begin fails++; $display("FAIL rand_tx_state%0d got dreq=%h empty=%b exp dreq=%h lvl=%0d", i, DREQ, dev_empty, exp_dreq(), txq.size()); end
        end
        tests++; if (err !== m_err || xfer_cnt !== exp_cnt()) begin fails++; $display("FAIL rand_tx_end got err=%b cnt=%h exp err=%b cnt=%h", err, xfer_cnt, m_err, exp_cnt()); end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_rx_burst();
        test_wait_states();
        test_tx_overflow();
        test_underflow();
        test_simul_push_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
